// File: rtl/arb_req_agent.sv
// rtl/arb_req_agent.sv - per-client pending-request counters feeding a single-cycle arbiter
module arb_req_agent #(
    parameter int N     = 16,
    parameter int CNT_W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] push_i,
    output logic [N-1:0] req_o,
    input  logic [N-1:0] gnt_i,
    output logic [N-1:0] full_o,
    output logic [N-1:0] drop_o,
    output logic         gnt_err_o,
    output logic [15:0]  gnt_cnt_o
);

    localparam logic [CNT_W-1:0] PMAX    = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [N-1:0]     VEC_ONE = N'(1);

    logic [CNT_W-1:0] pend_q [N];
    logic [CNT_W-1:0] pend_d [N];
    logic [N-1:0]     drop_q, drop_d;
    logic             gnt_err_q, gnt_err_d;
    logic [15:0]      gnt_cnt_q, gnt_cnt_d;

    logic             legal;
    logic [N-1:0]     vg;
    logic [N-1:0]     acc;

    // Request and full flags come only from the registered counters
    always_comb begin
        req_o  = '0;
        full_o = '0;
        for (int i = 0; i < N; i++) begin
            req_o[i]  = (pend_q[i] != '0);
            full_o[i] = (pend_q[i] == PMAX);
        end
    end

    // Grant legality, valid grants and push acceptance; a full client may
    // still accept a push when it is granted in the same cycle
    always_comb begin
        legal = ((gnt_i & (gnt_i - VEC_ONE)) == '0) && ((gnt_i & ~req_o) == '0);
        vg    = legal ? (gnt_i & req_o) : '0;
        acc   = push_i & (~full_o | vg);
    end

    // Next-state computation for counters and status outputs
    always_comb begin
        for (int i = 0; i < N; i++) begin
            pend_d[i] = pend_q[i];
            if (acc[i] && !vg[i]) begin
                pend_d[i] = pend_q[i] + CNT_ONE;
            end else if (!acc[i] && vg[i]) begin
                pend_d[i] = pend_q[i] - CNT_ONE;
            end
        end
        drop_d    = push_i & ~acc;
        gnt_err_d = gnt_err_q | ~legal;
        gnt_cnt_d = gnt_cnt_q;
        if (vg != '0) begin
            gnt_cnt_d = gnt_cnt_q + 16'd1;
        end
    end

    // State registers; reset discards pending work without a drop pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                pend_q[i] <= '0;
            end
            drop_q    <= '0;
            gnt_err_q <= 1'b0;
            gnt_cnt_q <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                pend_q[i] <= pend_d[i];
            end
            drop_q    <= drop_d;
            gnt_err_q <= gnt_err_d;
            gnt_cnt_q <= gnt_cnt_d;
        end
    end

    assign drop_o    = drop_q;
    assign gnt_err_o = gnt_err_q;
    assign gnt_cnt_o = gnt_cnt_q;

endmodule

// File: tb/tb_arb_req_agent.sv
// tb/tb_arb_req_agent.sv - self-checking bench for arb_req_agent
module tb_arb_req_agent;

    localparam int PMAX = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] push_i = '0;
    logic [15:0] gnt_i = '0;
    logic [15:0] req_o, full_o, drop_o, gnt_cnt_o;
    logic        gnt_err_o;

    int total = 0;
    int bad = 0;

    int          m_pend [16];
    logic [15:0] m_drop;
    logic        m_err;
    logic [15:0] m_cnt;

    arb_req_agent #(.N(16), .CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .push_i    (push_i),
        .req_o     (req_o),
        .gnt_i     (gnt_i),
        .full_o    (full_o),
        .drop_o    (drop_o),
        .gnt_err_o (gnt_err_o),
        .gnt_cnt_o (gnt_cnt_o)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] exp_req();
        logic [15:0] v = '0;
        for (int i = 0; i < 16; i++) v[i] = (m_pend[i] > 0);
        return v;
    endfunction

    function automatic logic [15:0] exp_full();
        logic [15:0] v = '0;
        for (int i = 0; i < 16; i++) v[i] = (m_pend[i] == PMAX);
        return v;
    endfunction

    // One clock: apply inputs, advance the reference model, settle at negedge
    task automatic drive_cycle(input logic [15:0] p, input logic [15:0] g, input logic r);
        logic [15:0] rq;
        bit          lg;
        bit          any_vg;
        push_i = p;
        gnt_i  = g;
        reset  = r;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 16; i++) m_pend[i] = 0;
            m_drop = '0;
            m_err  = 1'b0;
            m_cnt  = '0;
        end else begin
            rq     = exp_req();
            lg     = ($countones(g) <= 1) && ((g & ~rq) == 16'h0);
            any_vg = 0;
            for (int i = 0; i < 16; i++) begin
                bit v, a;
                v = lg && g[i] && rq[i];
                a = p[i] && ((m_pend[i] < PMAX) || v);
                m_pend[i] = m_pend[i] + int'(a) - int'(v);
                m_drop[i] = p[i] && !a;
                if (v) any_vg = 1;
            end
            if (!lg) m_err = 1'b1;
            if (any_vg) m_cnt = m_cnt + 16'd1;
        end
        @(negedge clk);
        push_i = '0;
        gnt_i  = '0;
        reset  = 1'b0;
    endtask

    task automatic test_reset();
        drive_cycle('0, '0, 1'b1);
        total++; if (req_o !== 16'h0) begin bad++; $display("FAIL reset_req: got %h want 0000", req_o); end
        total++; if (full_o !== 16'h0) begin bad++; $display("FAIL reset_full: got %h want 0000", full_o); end
        total++; if (drop_o !== 16'h0) begin bad++; $display("FAIL reset_drop: got %h want 0000", drop_o); end
        total++; if (gnt_err_o !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", gnt_err_o); end
        total++; if (gnt_cnt_o !== 16'h0) begin bad++; $display("FAIL reset_cnt: got %h want 0000", gnt_cnt_o); end
    endtask

    task automatic test_basic_push();
        drive_cycle('0, '0, 1'b1);
        drive_cycle(16'h0005, '0, 1'b0);
        total++; if (req_o !== 16'h0005) begin bad++; $display("FAIL basic_req: got %h want 0005", req_o); end
        total++; if (full_o !== 16'h0) begin bad++; $display("FAIL basic_full: got %h want 0000", full_o); end
        total++; if (gnt_cnt_o !== 16'h0) begin bad++; $display("FAIL basic_cnt: got %h want 0000", gnt_cnt_o); end
    endtask

    task automatic test_fill_and_drop();
        drive_cycle('0, '0, 1'b1);
        for (int k = 0; k < 14; k++) drive_cycle(16'h0008, '0, 1'b0);
        total++; if (full_o[3] !== 1'b0) begin bad++; $display("FAIL fill14_full: got %b want 0", full_o[3]); end
        drive_cycle(16'h0008, '0, 1'b0);
        total++; if (full_o !== 16'h0008) begin bad++; $display("FAIL fill15_full: got %h want 0008", full_o); end
        total++; if (drop_o !== 16'h0) begin bad++; $display("FAIL fill15_drop: got %h want 0000", drop_o); end
        drive_cycle(16'h0008, '0, 1'b0);
        total++; if (drop_o !== 16'h0008) begin bad++; $display("FAIL fill16_drop: got %h want 0008", drop_o); end
        total++; if (full_o !== 16'h0008) begin bad++; $display("FAIL fill16_full: got %h want 0008", full_o); end
        drive_cycle('0, '0, 1'b0);
        total++; if (drop_o !== 16'h0) begin bad++; $display("FAIL drop_pulse_len: got %h want 0000", drop_o); end
        // Full client with push and grant together: count holds, push accepted
        drive_cycle(16'h0008, 16'h0008, 1'b0);
        total++; if (drop_o !== 16'h0) begin bad++; $display("FAIL pushgnt_drop: got %h want 0000", drop_o); end
        total++; if (full_o !== 16'h0008) begin bad++; $display("FAIL pushgnt_full: got %h want 0008", full_o); end
        total++; if (gnt_cnt_o !== 16'd1) begin bad++; $display("FAIL pushgnt_cnt: got %0d want 1", gnt_cnt_o); end
        // One grant alone leaves 14 pending: no longer full, still requesting
        drive_cycle('0, 16'h0008, 1'b0);
        total++; if (full_o !== 16'h0 || req_o !== 16'h0008) begin bad++; $display("FAIL drain1: full %h req %h want 0000 0008", full_o, req_o); end
    endtask

    task automatic test_illegal_grant();
        drive_cycle('0, '0, 1'b1);
        drive_cycle(16'h0001, '0, 1'b0);
        drive_cycle('0, 16'h0003, 1'b0);
        total++; if (gnt_err_o !== 1'b1) begin bad++; $display("FAIL multihot_err: got %b want 1", gnt_err_o); end
        total++; if (req_o !== 16'h0001) begin bad++; $display("FAIL multihot_req: got %h want 0001", req_o); end
        total++; if (gnt_cnt_o !== 16'h0) begin bad++; $display("FAIL multihot_cnt: got %h want 0000", gnt_cnt_o); end
        drive_cycle('0, 16'h0001, 1'b0);
        total++; if (gnt_err_o !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", gnt_err_o); end
        total++; if (req_o !== 16'h0 || gnt_cnt_o !== 16'd1) begin bad++; $display("FAIL after_legal: req %h cnt %0d want 0000 1", req_o, gnt_cnt_o); end

        drive_cycle('0, '0, 1'b1);
        drive_cycle(16'h0001, '0, 1'b0);
        drive_cycle('0, 16'h0002, 1'b0);
        total++; if (gnt_err_o !== 1'b1) begin bad++; $display("FAIL idle_gnt_err: got %b want 1", gnt_err_o); end
        total++; if (req_o !== 16'h0001 || gnt_cnt_o !== 16'h0) begin bad++; $display("FAIL idle_gnt_state: req %h cnt %h want 0001 0000", req_o, gnt_cnt_o); end
    endtask

    task automatic test_arbiter_loop();
        logic [15:0] g;
        int          n;
        drive_cycle('0, '0, 1'b1);
        drive_cycle(16'hFFFF, '0, 1'b0);
        drive_cycle(16'hFFFF, '0, 1'b0);
        n = 0;
        while (req_o != 16'h0 && n < 200) begin
            g = req_o & (~req_o + 16'd1);
            drive_cycle('0, g, 1'b0);
            n++;
        end
        total++; if (gnt_cnt_o !== 16'd32) begin bad++; $display("FAIL arb_cnt: got %0d want 32", gnt_cnt_o); end
        total++; if (req_o !== 16'h0) begin bad++; $display("FAIL arb_req_end: got %h want 0000", req_o); end
        total++; if (gnt_err_o !== 1'b0) begin bad++; $display("FAIL arb_err: got %b want 0", gnt_err_o); end
        // Reset in the middle of activity clears everything with no drop pulse
        for (int k = 0; k < 16; k++) drive_cycle(16'h00F0, '0, 1'b0);
        drive_cycle(16'h00F0, 16'h0010, 1'b1);
        total++; if (req_o !== 16'h0 || full_o !== 16'h0) begin bad++; $display("FAIL midrst_req: req %h full %h want 0000 0000", req_o, full_o); end
        total++; if (drop_o !== 16'h0 || gnt_cnt_o !== 16'h0) begin bad++; $display("FAIL midrst_drop: drop %h cnt %h want 0000 0000", drop_o, gnt_cnt_o); end
    endtask

    task automatic test_random();
        logic [15:0] p, g, rq;
        int          idx;
        drive_cycle('0, '0, 1'b1);
        for (int c = 0; c < 1500; c++) begin
            p  = 16'($urandom) & 16'($urandom);
            rq = exp_req();
            g  = '0;
            if ($urandom_range(0, 19) == 0) begin
                g = 16'($urandom);
            end else if (rq != 16'h0 && $urandom_range(0, 3) != 0) begin
                do idx = $urandom_range(0, 15); while (!rq[idx]);
                g[idx] = 1'b1;
            end
            drive_cycle(p, g, $urandom_range(0, 99) == 0);
            total++; if (req_o !== exp_req()) begin bad++; $display("FAIL rnd_req c=%0d: got %h want %h", c, req_o, exp_req()); end
            total++; if (full_o !== exp_full()) begin bad++; $display("FAIL rnd_full c=%0d: got %h want %h", c, full_o, exp_full()); end
            total++; if (drop_o !== m_drop) begin bad++; $display("FAIL rnd_drop c=%0d: got %h want %h", c, drop_o, m_drop); end
            total++; if (gnt_err_o !== m_err) begin bad++; $display("FAIL rnd_err c=%0d: got %b want %b", c, gnt_err_o, m_err); end
            total++; if (gnt_cnt_o !== m_cnt) begin bad++; $display("FAIL rnd_cnt c=%0d: got %h want %h", c, gnt_cnt_o, m_cnt); end
        end
    endtask

    task automatic test_cnt_wrap();
        drive_cycle('0, '0, 1'b1);
        drive_cycle(16'h0001, '0, 1'b0);
        for (int k = 0; k < 65535; k++) drive_cycle(16'h0001, 16'h0001, 1'b0);
        total++; if (gnt_cnt_o !== 16'hFFFF) begin bad++; $display("FAIL wrap_ffff: got %h want ffff", gnt_cnt_o); end
        drive_cycle(16'h0001, 16'h0001, 1'b0);
        total++; if (gnt_cnt_o !== 16'h0000) begin bad++; $display("FAIL wrap_zero: got %h want 0000", gnt_cnt_o); end
        total++; if (req_o !== 16'h0001) begin bad++; $display("FAIL wrap_req: got %h want 0001", req_o); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) m_pend[i] = 0;
        m_drop = '0;
        m_err  = 1'b0;
        m_cnt  = '0;
        @(negedge clk);
        test_reset();
        test_basic_push();
        test_fill_and_drop();
        test_illegal_grant();
        test_arbiter_loop();
        test_random();
        test_cnt_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arb_req_agent.md
ARB_REQ_AGENT -- requirements
Module: arb_req_agent

Interface
REQ-001 The block SHALL have parameter N, default 16, meaning number of requesting clients (arbiter width).
REQ-002 The block SHALL have parameter CNT_W, default 4, meaning per-client pending-counter width; PMAX = 2^CNT_W-1.
REQ-003 The block SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port push_i  input  N  per-client request event, one pending transaction per set bit per cycle.
REQ-006 The block SHALL have port req_o  output  N  request vector driven into the single-cycle arbiter.
REQ-007 The block SHALL have port gnt_i  input  N  grant vector returned by the arbiter, same cycle as req_o.
REQ-008 The block SHALL have port full_o  output  N  client i pending count equals PMAX.
REQ-009 The block SHALL have port drop_o  output  N  registered one-cycle pulse, client i push was rejected.
REQ-010 The block SHALL have port gnt_err_o  output  1  sticky grant-protocol violation flag.
REQ-011 The block SHALL have port gnt_cnt_o  output  16  running count of valid grants, wraps.

Function
REQ-012 The block SHALL hold one CNT_W-bit pending counter pend[i] per client.
REQ-013 req_o[i] SHALL be 1 iff pend[i] != 0, decoded from registered state only; no combinational path from push_i or gnt_i to req_o.
REQ-014 full_o[i] SHALL be 1 iff pend[i] == PMAX, decoded from registered state only.
REQ-015 Grant legality per cycle: legal = gnt_i zero or one-hot, and (gnt_i & ~req_o) == 0.
REQ-016 Valid grant vg[i] SHALL be gnt_i[i] & req_o[i] when legal, else vg = 0 (illegal cycle decrements nothing).
REQ-017 Push accept: acc[i] = push_i[i] & (pend[i] < PMAX | vg[i]).
REQ-018 Next count: pend[i] <= pend[i] + acc[i] - vg[i]; never wraps below 0 or above PMAX.
REQ-019 Simultaneous push and valid grant on same client SHALL leave pend[i] unchanged, including at PMAX (push accepted, not dropped).
REQ-020 drop_o[i] SHALL be 1 in cycle t+1 iff push_i[i] & ~acc[i] in cycle t, else 0.
REQ-021 gnt_err_o SHALL be set in cycle t+1 if legal = 0 in cycle t and SHALL stay 1 until reset.
REQ-022 gnt_cnt_o SHALL increment by 1 in cycle t+1 for each cycle t with vg != 0; 16'hFFFF + 1 wraps to 0.
REQ-023 Latency: push in cycle t SHALL assert req_o[i] in cycle t+1 (if pend was 0); grant in cycle t SHALL deassert req_o[i] in cycle t+1 if pend was 1 and no push.
REQ-024 Clients SHALL be independent; pushes on multiple clients in one cycle SHALL all be evaluated in parallel.

Reset
REQ-025 While reset = 1 at a rising edge, all pend[i] SHALL become 0, drop_o = 0, gnt_err_o = 0, gnt_cnt_o = 0; push_i and gnt_i in that cycle SHALL be ignored.
REQ-026 In the cycle after reset, req_o = 0 and full_o = 0.
REQ-027 Reset mid-operation SHALL discard all pending transactions with no drop_o pulse.

Verification
REQ-028 Reset, push_i = 16'h0005 one cycle, gnt_i = 0 -> next cycle req_o = 16'h0005, full_o = 0, gnt_cnt_o = 0.
REQ-029 Push client 3 fifteen cycles, then one more push, no grants -> full_o[3] = 1 after 15th push, drop_o[3] pulses one cycle after 16th push, pend[3] stays 15.
REQ-030 pend[3] = 15, push_i[3] and gnt_i = 16'h0008 same cycle -> pend[3] stays 15, drop_o[3] = 0, gnt_cnt_o increments by 1.
REQ-031 req_o = 16'h0001, gnt_i = 16'h0003 -> gnt_err_o = 1 next cycle and stays 1; pend[0] unchanged; gnt_cnt_o unchanged.
REQ-032 req_o = 16'h0001, gnt_i = 16'h0002 (grant to idle client) -> gnt_err_o = 1, no counter changes.
REQ-033 Connect to single_cycle_arbiter (N = 16), push all clients twice, then idle -> 32 grants, gnt_cnt_o = 32, req_o = 0 at end, gnt_err_o = 0; assert reset mid-run -> req_o = 0 next cycle.
